// File: rtl/noc_test_packet_tx.sv
// Traffic generator for a NoC test node: sends cfg_num_pkts packets of cfg_pkt_len flits to one router.
// Latency: header valid the cycle after send_start; one flit per cycle while ready; GAP_CYCLES idle between packets.
// Backpressure: valid/ready; flit and flags are held stable while valid && !ready.
// Ports: noc_clk / noc_rst_n         clock, asynchronous active-low reset
//        send_start, cfg_*           run start pulse and run setup (latched on an accepted start)
//        sender_*                    flit interface towards the router local port
//        busy, done, pkts_sent       run status
module noc_test_packet_tx #(
  parameter int X_ID       = 0,
  parameter int Y_ID       = 0,
  parameter int DATA_WIDTH = 32,
  parameter int ID_W       = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  input  logic                  send_start,
  input  logic [ID_W-1:0]       cfg_dst_x,
  input  logic [ID_W-1:0]       cfg_dst_y,
  input  logic [7:0]            cfg_pkt_len,
  input  logic [15:0]           cfg_num_pkts,
  output logic                  sender_valid,
  input  logic                  sender_ready,
  output logic [DATA_WIDTH-1:0] sender_flit,
  output logic                  sender_is_header,
  output logic                  sender_is_tail,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           pkts_sent
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  localparam logic [3:0] SRC_X   = 4'(X_ID);
  localparam logic [3:0] SRC_Y   = 4'(Y_ID);
  localparam logic [7:0] GAP_TOP = 8'(GAP_CYCLES - 1);

  logic [1:0]      state;
  logic [7:0]      idx;       // flit index inside the current packet
  logic [7:0]      len_q;     // effective packet length (never 0)
  logic [15:0]     num_q;
  logic [ID_W-1:0] dst_x_q;
  logic [ID_W-1:0] dst_y_q;
  logic [15:0]     seq;       // survives between runs, cleared only by reset
  logic [7:0]      gap_cnt;
  logic            last_flit;
  logic            more_pkts;

  // Outputs are decoded from registered state only, so they cannot change while a flit is stalled.
  assign sender_valid     = (state == SEND);
  assign busy             = (state != IDLE);
  assign sender_is_header = (state == SEND) && (idx == 8'd0);
  assign sender_is_tail   = (state == SEND) && last_flit;
  assign last_flit        = (idx == len_q - 8'd1);
  assign more_pkts        = ({1'b0, pkts_sent} + 17'd1) < {1'b0, num_q};

  always_comb begin
    sender_flit = '0;
    if (state == SEND) begin
      if (idx == 8'd0) begin
        sender_flit[31:0] = {4'(dst_x_q), 4'(dst_y_q), SRC_X, SRC_Y, seq[7:0], len_q};
      end else begin
        sender_flit[31:0] = {seq, 8'h00, idx};
      end
    end
  end

  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state     <= IDLE;
      idx       <= 8'd0;
      len_q     <= 8'd0;
      num_q     <= 16'd0;
      dst_x_q   <= '0;
      dst_y_q   <= '0;
      seq       <= 16'd0;
      gap_cnt   <= 8'd0;
      done      <= 1'b0;
      pkts_sent <= 16'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (send_start) begin
            if (cfg_num_pkts != 16'd0) begin
              dst_x_q   <= cfg_dst_x;
              dst_y_q   <= cfg_dst_y;
              len_q     <= (cfg_pkt_len == 8'd0) ? 8'd1 : cfg_pkt_len;
              num_q     <= cfg_num_pkts;
              pkts_sent <= 16'd0;
              idx       <= 8'd0;
              state     <= SEND;
            end else begin
              // Empty run: report completion without touching the link or the counters.
              done <= 1'b1;
            end
          end
        end
        SEND: begin
          if (sender_ready) begin
            if (last_flit) begin
              seq       <= seq + 16'd1;
              pkts_sent <= pkts_sent + 16'd1;
              idx       <= 8'd0;
              if (more_pkts) begin
                if (GAP_CYCLES > 0) begin
                  gap_cnt <= GAP_TOP;
                  state   <= GAP;
                end
              end else begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end else begin
              idx <= idx + 8'd1;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 8'd0) begin
            state <= SEND;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_test_packet_tx.sv
module tb_noc_test_packet_tx;

  logic        clk;
  logic        rst_n;
  logic        start0, start2;
  logic [3:0]  dst_x, dst_y;
  logic [7:0]  pkt_len;
  logic [15:0] num_pkts;
  logic        ready;

  logic        v0, h0, t0, b0, d0;
  logic [31:0] f0;
  logic [15:0] p0;
  logic        v2, h2, t2, b2, d2;
  logic [31:0] f2;
  logic [15:0] p2;

  logic        sel;
  logic        m_valid, m_hdr, m_tail, m_busy, m_done;
  logic [31:0] m_flit;
  logic [15:0] m_pkts;

  int errors = 0;
  int checks = 0;

  logic [31:0] q_flit[$];
  logic        q_hdr[$];
  logic        q_tail[$];
  int          q_gap[$];
  logic [31:0] exp_f[$];
  logic        exp_h[$];
  logic        exp_t[$];
  int          first_k, last_k, done_k;

  noc_test_packet_tx #(.X_ID(1), .Y_ID(2), .DATA_WIDTH(32), .ID_W(4), .GAP_CYCLES(0)) dut0 (
    .noc_clk(clk), .noc_rst_n(rst_n), .send_start(start0),
    .cfg_dst_x(dst_x), .cfg_dst_y(dst_y), .cfg_pkt_len(pkt_len), .cfg_num_pkts(num_pkts),
    .sender_valid(v0), .sender_ready(ready), .sender_flit(f0),
    .sender_is_header(h0), .sender_is_tail(t0),
    .busy(b0), .done(d0), .pkts_sent(p0)
  );

  noc_test_packet_tx #(.X_ID(1), .Y_ID(2), .DATA_WIDTH(32), .ID_W(4), .GAP_CYCLES(2)) dut2 (
    .noc_clk(clk), .noc_rst_n(rst_n), .send_start(start2),
    .cfg_dst_x(dst_x), .cfg_dst_y(dst_y), .cfg_pkt_len(pkt_len), .cfg_num_pkts(num_pkts),
    .sender_valid(v2), .sender_ready(ready), .sender_flit(f2),
    .sender_is_header(h2), .sender_is_tail(t2),
    .busy(b2), .done(d2), .pkts_sent(p2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    m_valid = sel ? v2 : v0;
    m_hdr   = sel ? h2 : h0;
    m_tail  = sel ? t2 : t0;
    m_busy  = sel ? b2 : b0;
    m_done  = sel ? d2 : d0;
    m_flit  = sel ? f2 : f0;
    m_pkts  = sel ? p2 : p0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int k);
    if (mode == 0) return 1'b1;
    return (k % 3 == 0);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start0 = 1'b0; start2 = 1'b0; ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Starts a run on the selected DUT, logs every accepted flit and every idle gap between
  // packets, checks that stalled flits stay put, and returns once done is seen.
  task automatic run(input int mode, input int restart_at, input int max_cyc);
    logic        prev_stall, prev_h, prev_t, got_done, in_gap;
    logic [31:0] prev_flit;
    int          idle;
    q_flit.delete(); q_hdr.delete(); q_tail.delete(); q_gap.delete();
    prev_stall = 1'b0; prev_h = 1'b0; prev_t = 1'b0; prev_flit = '0;
    got_done = 1'b0; in_gap = 1'b0; idle = 0;
    first_k = -1; last_k = -1; done_k = -1;
    @(negedge clk);
    if (sel) start2 = 1'b1; else start0 = 1'b1;
    ready = rdy(mode, 0);
    for (int k = 1; k <= max_cyc && !got_done; k++) begin
      @(negedge clk);
      start0 = 1'b0; start2 = 1'b0;
      if (k == restart_at) begin
        dst_x = 4'd9; dst_y = 4'd9; pkt_len = 8'd1; num_pkts = 16'd1;
        if (sel) start2 = 1'b1; else start0 = 1'b1;
      end
      ready = rdy(mode, k);
      if (prev_stall) begin
        chk("stall_valid_held", 32'(m_valid), 32'd1);
        chk("stall_flit_held", m_flit, prev_flit);
        chk("stall_flags_held", 32'({m_hdr, m_tail}), 32'({prev_h, prev_t}));
      end
      if (m_done) begin
        got_done = 1'b1;
        done_k = k;
        chk("valid_low_at_done", 32'(m_valid), 32'd0);
      end else if (m_valid) begin
        if (in_gap) begin
          q_gap.push_back(idle);
          in_gap = 1'b0;
        end
        if (ready) begin
          q_flit.push_back(m_flit); q_hdr.push_back(m_hdr); q_tail.push_back(m_tail);
          if (first_k < 0) first_k = k;
          last_k = k;
          if (m_tail) begin
            in_gap = 1'b1;
            idle = 0;
          end
        end
        prev_stall = !ready; prev_flit = m_flit; prev_h = m_hdr; prev_t = m_tail;
      end else begin
        prev_stall = 1'b0;
        if (in_gap) idle++;
      end
    end
    start0 = 1'b0; start2 = 1'b0;
    chk("done_seen", 32'(got_done), 32'd1);
  endtask

  task automatic chk_flits(input string tag);
    chk({tag, "_count"}, 32'(q_flit.size()), 32'(exp_f.size()));
    for (int i = 0; i < exp_f.size(); i++) begin
      if (i < q_flit.size()) begin
        chk({tag, "_flit"}, q_flit[i], exp_f[i]);
        chk({tag, "_flags"}, 32'({q_hdr[i], q_tail[i]}), 32'({exp_h[i], exp_t[i]}));
      end
    end
  endtask

  initial begin
    sel = 1'b0; rst_n = 1'b0; start0 = 1'b0; start2 = 1'b0; ready = 1'b0;
    dst_x = 4'd0; dst_y = 4'd0; pkt_len = 8'd0; num_pkts = 16'd0;

    // Reset state of both instances
    #1;
    chk("rst_outputs0", 32'({v0, h0, t0, b0, d0}), 32'd0);
    chk("rst_flit0", f0, 32'd0);
    chk("rst_pkts0", 32'(p0), 32'd0);
    chk("rst_outputs2", 32'({v2, h2, t2, b2, d2}), 32'd0);
    do_reset();

    // One 4-flit packet to (3,0)
    sel = 1'b0; dst_x = 4'd3; dst_y = 4'd0; pkt_len = 8'd4; num_pkts = 16'd1;
    run(0, 0, 50);
    exp_f = '{32'h3012_0004, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003};
    exp_h = '{1'b1, 1'b0, 1'b0, 1'b0};
    exp_t = '{1'b0, 1'b0, 1'b0, 1'b1};
    chk_flits("single_pkt");
    chk("hdr_latency", 32'(first_k), 32'd1);
    chk("back_to_back", 32'(last_k), 32'd4);
    chk("done_after_tail", 32'(done_k - last_k), 32'd1);
    chk("pkts_sent_1", 32'(m_pkts), 32'd1);
    chk("busy_low_at_done", 32'(m_busy), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(m_done), 32'd0);
    chk("pkts_sent_held", 32'(m_pkts), 32'd1);

    // Three single-flit packets, no gap
    do_reset();
    pkt_len = 8'd1; num_pkts = 16'd3;
    run(0, 0, 50);
    exp_f = '{32'h3012_0001, 32'h3012_0101, 32'h3012_0201};
    exp_h = '{1'b1, 1'b1, 1'b1};
    exp_t = '{1'b1, 1'b1, 1'b1};
    chk_flits("len1");
    chk("len1_consecutive", 32'(last_k - first_k), 32'd2);
    chk("pkts_sent_3", 32'(m_pkts), 32'd3);

    // Gap instance with a stalling receiver
    sel = 1'b1; pkt_len = 8'd3; num_pkts = 16'd2;
    run(1, 0, 80);
    exp_f = '{32'h3012_0003, 32'h0000_0001, 32'h0000_0002,
              32'h3012_0103, 32'h0001_0001, 32'h0001_0002};
    exp_h = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    chk_flits("gap_run");
    chk("gap_count", 32'(q_gap.size()), 32'd1);
    if (q_gap.size() > 0) chk("gap_len", 32'(q_gap[0]), 32'd2);
    chk("pkts_sent_2", 32'(m_pkts), 32'd2);

    // A second start during a run is ignored
    do_reset();
    sel = 1'b0; dst_x = 4'd5; dst_y = 4'd6; pkt_len = 8'd2; num_pkts = 16'd3;
    run(0, 2, 50);
    exp_f = '{32'h5612_0002, 32'h0000_0001, 32'h5612_0102,
              32'h0001_0001, 32'h5612_0202, 32'h0002_0001};
    exp_h = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_t = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    chk_flits("restart_ignored");
    chk("restart_pkts_sent", 32'(m_pkts), 32'd3);
    @(negedge clk);
    chk("restart_no_new_run", 32'({m_valid, m_busy}), 32'd0);

    // Reset in the middle of a 5-flit packet
    do_reset();
    dst_x = 4'd3; dst_y = 4'd0; pkt_len = 8'd5; num_pkts = 16'd1;
    @(negedge clk); start0 = 1'b1; ready = 1'b1;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_pkt_third_flit", f0, 32'h0000_0002);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid_busy", 32'({v0, b0}), 32'd0);
    chk("mid_rst_pkts", 32'(p0), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    pkt_len = 8'd1; num_pkts = 16'd1;
    run(0, 0, 20);
    exp_f = '{32'h3012_0001};
    exp_h = '{1'b1};
    exp_t = '{1'b1};
    chk_flits("after_rst");

    // Sequence number wrap
    do_reset();
    pkt_len = 8'd1; num_pkts = 16'hFFFF;
    run(0, 0, 70000);
    chk("preload_count", 32'(q_flit.size()), 32'd65535);
    chk("preload_pkts_sent", 32'(m_pkts), 32'h0000_FFFF);
    num_pkts = 16'd2;
    run(0, 0, 20);
    exp_f = '{32'h3012_FF01, 32'h3012_0001};
    exp_h = '{1'b1, 1'b1};
    exp_t = '{1'b1, 1'b1};
    chk_flits("seq_wrap");

    // Zero-packet run
    num_pkts = 16'd0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    chk("zero_done", 32'(d0), 32'd1);
    chk("zero_valid_busy", 32'({v0, b0}), 32'd0);
    chk("zero_pkts_held", 32'(p0), 32'd2);
    @(negedge clk);
    chk("zero_done_pulse", 32'({d0, v0}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
